// File: rtl/ddr_rd_burst_sched_pkg.sv
// Shared encodings for the DDR read-burst scheduler: AXI burst type, FSM states
// and the burst-size helper.
package ddr_rd_burst_sched_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_GAP   = 2'b10
    } state_e;

    function automatic int unsigned burst_bytes(input int unsigned beats,
                                                input int unsigned beat_bytes);
        return beats * beat_bytes;
    endfunction

endpackage

// File: rtl/ddr_rd_burst_sched_sat_cnt.sv
// Saturating up/down counter; an increment while at all-ones raises ovf for
// that cycle, a decrement at zero is dropped.
module sat_updown_cnt #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] cnt_nxt,
    output logic [W-1:0] cnt,
    output logic         ovf
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         ovf_s;

    // Next count: clear wins, simultaneous inc/dec cancel.
    always_comb begin
        cnt_d = cnt_q;
        ovf_s = 1'b0;
        if (clr) begin
            cnt_d = {W{1'b0}};
        end else if (inc && !dec) begin
            if (cnt_q == {W{1'b1}}) begin
                ovf_s = 1'b1;
            end else begin
                cnt_d = cnt_q + W'(1);
            end
        end else if (dec && !inc) begin
            if (cnt_q != {W{1'b0}}) begin
                cnt_d = cnt_q - W'(1);
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_nxt = cnt_d;
    assign cnt     = cnt_q;
    assign ovf     = ovf_s;

endmodule

// File: rtl/ddr_rd_burst_sched.sv
// AXI read-address scheduler: issues ring-buffer read bursts on FIFO refill
// requests, metered by write credits, an outstanding limit and a holdoff gap.
module ddr_rd_burst_sched
    import ddr_rd_burst_sched_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned BURST_BEATS = 16,
    parameter int unsigned BEAT_BYTES  = 32,
    parameter int unsigned MAX_OUTST   = 4,
    parameter int unsigned HOLDOFF     = 8,
    parameter int unsigned CRED_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ctrl_rd_en,
    input  logic              DDR_rd_en,
    input  logic [ADDR_W-1:0] cfg_base_addr,
    input  logic [15:0]       cfg_num_bursts,
    input  logic              wr_burst_done,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic [7:0]        m_axi_arlen,
    output logic [2:0]        m_axi_arsize,
    output logic [1:0]        m_axi_arburst,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic              m_axi_rvalid,
    input  logic              m_axi_rready,
    input  logic              m_axi_rlast,
    output logic [CRED_W-1:0] credits,
    output logic [2:0]        outstanding,
    output logic              underrun,
    output logic              cred_ovf,
    output logic              busy
);

    localparam int unsigned BURST_BYTES = burst_bytes(BURST_BEATS, BEAT_BYTES);
    localparam int unsigned GAP_W       = $clog2(HOLDOFF + 1);

    state_e            state_q, state_d;
    logic              arvalid_q, arvalid_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [15:0]       num_q, num_d;
    logic [15:0]       idx_q, idx_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              ctrl_q;
    logic              pend_q, pend_d;
    logic              underrun_q, underrun_d;
    logic              cred_ovf_q, cred_ovf_d;
    logic              busy_q, busy_d;

    logic              ar_hs_s, r_last_s, rise_s, apply_s, want_s, issue_s;
    logic              cred_ovf_s, outst_ovf_unused_s;
    logic [CRED_W-1:0] cred_nxt_unused_s;
    logic [2:0]        outst_nxt_s;

    assign ar_hs_s  = arvalid_q & m_axi_arready;
    assign r_last_s = m_axi_rvalid & m_axi_rready & m_axi_rlast;
    assign rise_s   = ctrl_rd_en & ~ctrl_q;
    // A rising edge caught mid-burst is deferred until the FSM is back in IDLE.
    assign apply_s  = (state_q == ST_IDLE) & (rise_s | pend_q);
    assign want_s   = ctrl_rd_en & DDR_rd_en;
    assign issue_s  = (state_q == ST_IDLE) & ~apply_s & want_s &
                      (credits != {CRED_W{1'b0}}) & (32'(outstanding) < MAX_OUTST);

    sat_updown_cnt #(.W(CRED_W)) u_cred_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (apply_s),
        .inc     (wr_burst_done),
        .dec     (ar_hs_s),
        .cnt_nxt (cred_nxt_unused_s),
        .cnt     (credits),
        .ovf     (cred_ovf_s)
    );

    sat_updown_cnt #(.W(3)) u_outst_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (1'b0),
        .inc     (ar_hs_s),
        .dec     (r_last_s),
        .cnt_nxt (outst_nxt_s),
        .cnt     (outstanding),
        .ovf     (outst_ovf_unused_s)
    );

    // FSM next state, ring address walk and sticky status flags.
    always_comb begin
        state_d    = state_q;
        arvalid_d  = arvalid_q;
        araddr_d   = araddr_q;
        base_d     = base_q;
        num_d      = num_q;
        idx_d      = idx_q;
        gap_d      = gap_q;
        pend_d     = pend_q;
        underrun_d = underrun_q;
        cred_ovf_d = cred_ovf_q | cred_ovf_s;

        case (state_q)
            ST_IDLE: begin
                if (issue_s) begin
                    state_d   = ST_ISSUE;
                    arvalid_d = 1'b1;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (ar_hs_s) begin
                    state_d   = ST_GAP;
                    arvalid_d = 1'b0;
                    gap_d     = {GAP_W{1'b0}};
                    if (({1'b0, idx_q} + 17'd1) >= {1'b0, num_q}) begin
                        idx_d    = 16'd0;
                        araddr_d = base_q;
                    end else begin
                        idx_d    = idx_q + 16'd1;
                        araddr_d = araddr_q + ADDR_W'(BURST_BYTES);
                    end
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_W'(HOLDOFF - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: begin
                state_d   = ST_IDLE;
                arvalid_d = 1'b0;
            end
        endcase

        if (apply_s) begin
            pend_d     = 1'b0;
            idx_d      = 16'd0;
            araddr_d   = cfg_base_addr;
            base_d     = cfg_base_addr;
            num_d      = cfg_num_bursts;
            underrun_d = 1'b0;
            cred_ovf_d = 1'b0;
        end else begin
            if (rise_s) begin
                pend_d = 1'b1;
            end else begin
                pend_d = pend_q;
            end
            if ((state_q == ST_IDLE) && want_s && (credits == {CRED_W{1'b0}})) begin
                underrun_d = 1'b1;
            end else begin
                underrun_d = underrun_q;
            end
        end

        busy_d = (state_d != ST_IDLE) | (outst_nxt_s != 3'd0);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            arvalid_q  <= 1'b0;
            araddr_q   <= {ADDR_W{1'b0}};
            base_q     <= {ADDR_W{1'b0}};
            num_q      <= 16'd0;
            idx_q      <= 16'd0;
            gap_q      <= {GAP_W{1'b0}};
            ctrl_q     <= 1'b0;
            pend_q     <= 1'b0;
            underrun_q <= 1'b0;
            cred_ovf_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            arvalid_q  <= arvalid_d;
            araddr_q   <= araddr_d;
            base_q     <= base_d;
            num_q      <= num_d;
            idx_q      <= idx_d;
            gap_q      <= gap_d;
            ctrl_q     <= ctrl_rd_en;
            pend_q     <= pend_d;
            underrun_q <= underrun_d;
            cred_ovf_q <= cred_ovf_d;
            busy_q     <= busy_d;
        end
    end

    assign m_axi_araddr  = araddr_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_arlen   = 8'(BURST_BEATS - 1);
    assign m_axi_arsize  = 3'($clog2(BEAT_BYTES));
    assign m_axi_arburst = AXI_BURST_INCR;
    assign underrun      = underrun_q;
    assign cred_ovf      = cred_ovf_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_ddr_rd_burst_sched.sv
// Directed self-checking bench for ddr_rd_burst_sched with hand-computed
// expectations.
module tb_ddr_rd_burst_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ctrl_rd_en = 1'b0;
    logic        DDR_rd_en = 1'b0;
    logic [31:0] cfg_base_addr = 32'h0;
    logic [15:0] cfg_num_bursts = 16'd1;
    logic        wr_burst_done = 1'b0;
    logic [31:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arvalid;
    logic        m_axi_arready = 1'b0;
    logic        m_axi_rvalid = 1'b0;
    logic        m_axi_rready = 1'b0;
    logic        m_axi_rlast = 1'b0;
    logic [15:0] credits;
    logic [2:0]  outstanding;
    logic        underrun;
    logic        cred_ovf;
    logic        busy;

    int errs = 0;
    int checks = 0;

    ddr_rd_burst_sched dut (
        .clk(clk), .rst_n(rst_n), .ctrl_rd_en(ctrl_rd_en), .DDR_rd_en(DDR_rd_en),
        .cfg_base_addr(cfg_base_addr), .cfg_num_bursts(cfg_num_bursts),
        .wr_burst_done(wr_burst_done), .m_axi_araddr(m_axi_araddr),
        .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
        .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready), .m_axi_rlast(m_axi_rlast),
        .credits(credits), .outstanding(outstanding), .underrun(underrun),
        .cred_ovf(cred_ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rlast_pulse();
        m_axi_rvalid = 1'b1; m_axi_rready = 1'b1; m_axi_rlast = 1'b1;
        tick();
        m_axi_rvalid = 1'b0; m_axi_rready = 1'b0; m_axi_rlast = 1'b0;
    endtask

    task automatic wait_ar(output int n);
        n = 0;
        while (m_axi_arvalid !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        chk("ar_seen", {63'd0, m_axi_arvalid}, 64'd1);
    endtask

    task automatic reenable();
        ctrl_rd_en = 1'b0;
        tick();
        ctrl_rd_en = 1'b1;
        repeat (12) tick();
    endtask

    logic [31:0] exp_addr [5];
    int n;
    int ar_cnt;
    logic seen;

    initial begin
        exp_addr[0] = 32'h1000_0000; exp_addr[1] = 32'h1000_0200;
        exp_addr[2] = 32'h1000_0400; exp_addr[3] = 32'h1000_0000;
        exp_addr[4] = 32'h1000_0200;

        // Reset state
        repeat (3) tick();
        chk("rst_arvalid", {63'd0, m_axi_arvalid}, 64'd0);
        chk("rst_araddr", {32'd0, m_axi_araddr}, 64'd0);
        chk("rst_credits", {48'd0, credits}, 64'd0);
        chk("rst_outst", {61'd0, outstanding}, 64'd0);
        chk("rst_flags", {62'd0, underrun, cred_ovf}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("arlen", {56'd0, m_axi_arlen}, 64'd15);
        chk("arsize", {61'd0, m_axi_arsize}, 64'd5);
        chk("arburst", {62'd0, m_axi_arburst}, 64'd1);
        rst_n = 1'b1;
        tick();

        // Ring walk with wrap, 5 credits, prompt R
        cfg_base_addr = 32'h1000_0000;
        cfg_num_bursts = 16'd3;
        ctrl_rd_en = 1'b1;
        tick();
        wr_burst_done = 1'b1;
        repeat (5) tick();
        wr_burst_done = 1'b0;
        tick();
        chk("t1_credits5", {48'd0, credits}, 64'd5);
        chk("t1_no_underrun", {63'd0, underrun}, 64'd0);
        m_axi_arready = 1'b1;
        DDR_rd_en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_ar(n);
            if (k == 1) chk("t1_holdoff", 64'(n), 64'd8);
            chk($sformatf("t1_araddr%0d", k), {32'd0, m_axi_araddr}, {32'd0, exp_addr[k]});
            tick();
            chk("t1_arvalid_drop", {63'd0, m_axi_arvalid}, 64'd0);
            rlast_pulse();
        end
        repeat (14) tick();
        chk("t1_credits0", {48'd0, credits}, 64'd0);
        chk("t1_outst0", {61'd0, outstanding}, 64'd0);
        chk("t1_underrun", {63'd0, underrun}, 64'd1);
        chk("t1_idle_arvalid", {63'd0, m_axi_arvalid}, 64'd0);
        chk("t1_idle_busy", {63'd0, busy}, 64'd0);

        // arready stalled, ctrl_rd_en dropped while AR pending
        DDR_rd_en = 1'b0;
        m_axi_arready = 1'b0;
        cfg_base_addr = 32'h2000_0000;
        cfg_num_bursts = 16'd2;
        reenable();
        chk("t2_underrun_clr", {63'd0, underrun}, 64'd0);
        wr_burst_done = 1'b1;
        tick();
        wr_burst_done = 1'b0;
        DDR_rd_en = 1'b1;
        wait_ar(n);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) ctrl_rd_en = 1'b0;
            chk("t2_hold_arvalid", {63'd0, m_axi_arvalid}, 64'd1);
            chk("t2_hold_araddr", {32'd0, m_axi_araddr}, 64'h2000_0000);
            tick();
        end
        m_axi_arready = 1'b1;
        tick();
        m_axi_arready = 1'b0;
        chk("t2_hs_arvalid", {63'd0, m_axi_arvalid}, 64'd0);
        chk("t2_outst1", {61'd0, outstanding}, 64'd1);
        chk("t2_credits0", {48'd0, credits}, 64'd0);
        wr_burst_done = 1'b1;
        tick();
        wr_burst_done = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            seen = seen | m_axi_arvalid;
            tick();
        end
        chk("t2_no_more_ar", {63'd0, seen}, 64'd0);
        chk("t2_credits1", {48'd0, credits}, 64'd1);
        chk("t2_underrun", {63'd0, underrun}, 64'd0);
        rlast_pulse();

        // Outstanding limit with no R responses
        DDR_rd_en = 1'b0;
        cfg_base_addr = 32'h3000_0000;
        cfg_num_bursts = 16'd3;
        reenable();
        wr_burst_done = 1'b1;
        repeat (10) tick();
        wr_burst_done = 1'b0;
        tick();
        chk("t3_credits10", {48'd0, credits}, 64'd10);
        m_axi_arready = 1'b1;
        DDR_rd_en = 1'b1;
        ar_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            if (m_axi_arvalid === 1'b1) ar_cnt++;
            tick();
        end
        chk("t3_ar_count", 64'(ar_cnt), 64'd4);
        chk("t3_outst4", {61'd0, outstanding}, 64'd4);
        chk("t3_credits6", {48'd0, credits}, 64'd6);
        chk("t3_stall", {63'd0, m_axi_arvalid}, 64'd0);
        chk("t3_busy", {63'd0, busy}, 64'd1);
        rlast_pulse();
        wait_ar(n);
        chk("t3_fifth_addr", {32'd0, m_axi_araddr}, 64'h3000_0200);
        tick();
        chk("t3_outst_back4", {61'd0, outstanding}, 64'd4);
        chk("t3_credits5", {48'd0, credits}, 64'd5);

        // Deferred enable edge, coincident credit/handshake, single-burst ring
        DDR_rd_en = 1'b0;
        m_axi_rvalid = 1'b1; m_axi_rready = 1'b1; m_axi_rlast = 1'b1;
        repeat (4) tick();
        m_axi_rvalid = 1'b0; m_axi_rready = 1'b0; m_axi_rlast = 1'b0;
        chk("t4_drained", {61'd0, outstanding}, 64'd0);
        cfg_base_addr = 32'h4000_0000;
        cfg_num_bursts = 16'd1;
        reenable();
        chk("t4_deferred_clr", {48'd0, credits}, 64'd0);
        wr_burst_done = 1'b1;
        tick();
        wr_burst_done = 1'b0;
        chk("t4_credits1", {48'd0, credits}, 64'd1);
        DDR_rd_en = 1'b1;
        wait_ar(n);
        chk("t4_addr_a", {32'd0, m_axi_araddr}, 64'h4000_0000);
        wr_burst_done = 1'b1;
        tick();
        wr_burst_done = 1'b0;
        chk("t4_coincident", {48'd0, credits}, 64'd1);
        chk("t4_outst1", {61'd0, outstanding}, 64'd1);
        wait_ar(n);
        chk("t4_addr_b", {32'd0, m_axi_araddr}, 64'h4000_0000);
        tick();
        DDR_rd_en = 1'b0;
        chk("t4_credits0", {48'd0, credits}, 64'd0);
        chk("t4_outst2", {61'd0, outstanding}, 64'd2);

        // Credit saturation
        m_axi_rvalid = 1'b1; m_axi_rready = 1'b1; m_axi_rlast = 1'b1;
        repeat (2) tick();
        m_axi_rvalid = 1'b0; m_axi_rready = 1'b0; m_axi_rlast = 1'b0;
        reenable();
        wr_burst_done = 1'b1;
        repeat (65535) tick();
        chk("t5_credits_max", {48'd0, credits}, 64'hFFFF);
        chk("t5_no_ovf", {63'd0, cred_ovf}, 64'd0);
        tick();
        wr_burst_done = 1'b0;
        chk("t5_credits_sat", {48'd0, credits}, 64'hFFFF);
        chk("t5_ovf", {63'd0, cred_ovf}, 64'd1);
        reenable();
        chk("t5_ovf_clr", {63'd0, cred_ovf}, 64'd0);

        // Async reset during ISSUE
        wr_burst_done = 1'b1;
        tick();
        wr_burst_done = 1'b0;
        m_axi_arready = 1'b0;
        DDR_rd_en = 1'b1;
        wait_ar(n);
        chk("t6_pre_credits", {48'd0, credits}, 64'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_arvalid", {63'd0, m_axi_arvalid}, 64'd0);
        chk("t6_araddr", {32'd0, m_axi_araddr}, 64'd0);
        chk("t6_credits", {48'd0, credits}, 64'd0);
        chk("t6_outst", {61'd0, outstanding}, 64'd0);
        chk("t6_busy", {63'd0, busy}, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/ddr_rd_burst_sched.md
# ddr_rd_burst_sched

AXI read-address scheduler in the DDR (AXI) clock domain. It turns the synchronized refill request from the read-side FIFO (`DDR_rd_en`) into AXI4 read bursts over a ring-buffer region of DDR. It meters bursts against write-side credits and an outstanding-burst limit, and applies a holdoff so the slow, synchronizer-delayed request cannot over-fetch. R data bypasses this block and goes straight into the read FIFO; only R-channel handshakes are monitored here.

## Interface
Parameters:
- `ADDR_W`, 32, AXI address width
- `BURST_BEATS`, 16, beats per burst; `arlen` = `BURST_BEATS-1`
- `BEAT_BYTES`, 32, bytes per beat; `arsize` = log2(`BEAT_BYTES`)
- `MAX_OUTST`, 4, maximum AR-accepted bursts whose `rlast` has not yet been seen
- `HOLDOFF`, 8, idle cycles after each AR handshake before the next issue decision
- `CRED_W`, 16, credit counter width

Ports:
- `clk`, in, 1: AXI clock
- `rst_n`, in, 1: asynchronous, active-low reset
- `ctrl_rd_en`, in, 1: playback enable, level, already in `clk` domain
- `DDR_rd_en`, in, 1: FIFO refill request, level, already in `clk` domain
- `cfg_base_addr`, in, `ADDR_W`: ring base address; must be burst-aligned
- `cfg_num_bursts`, in, 16: ring size in bursts; must be ≥1; sampled on the `ctrl_rd_en` rising edge
- `wr_burst_done`, in, 1: one-cycle pulse, one burst committed to DDR by the writer
- `m_axi_araddr`, out, `ADDR_W`
- `m_axi_arlen`, out, 8: constant
- `m_axi_arsize`, out, 3: constant
- `m_axi_arburst`, out, 2: constant INCR (2'b01)
- `m_axi_arvalid`, out, 1
- `m_axi_arready`, in, 1
- `m_axi_rvalid`, in, 1: monitor only
- `m_axi_rready`, in, 1: monitor only
- `m_axi_rlast`, in, 1: monitor only
- `credits`, out, `CRED_W`: bursts written but not yet requested
- `outstanding`, out, 3: in-flight burst count
- `underrun`, out, 1: sticky
- `cred_ovf`, out, 1: sticky
- `busy`, out, 1: state ≠ IDLE or `outstanding` ≠ 0

## Operation
- States:
  - IDLE → ISSUE when `ctrl_rd_en & DDR_rd_en & credits≠0 & outstanding<MAX_OUTST`.
  - ISSUE (`arvalid`=1) → GAP on `arready`.
  - GAP counts `HOLDOFF` cycles, then → IDLE.
- In ISSUE, `araddr` and `arvalid` are held stable until handshake. `arvalid` is never withdrawn, even if `ctrl_rd_en` falls.
- `ctrl_rd_en` low: no new ISSUE. A pending AR completes. GAP runs out normally.
- `ctrl_rd_en` rising edge, IDLE only:
  - ring index ← 0, `araddr` ← `cfg_base_addr`;
  - credits ← 0;
  - `underrun` and `cred_ovf` ← 0;
  - `cfg_num_bursts` latched.
  - A rising edge seen outside IDLE is remembered and applied on the next IDLE entry.
- Address: on AR handshake, idx+1 and `araddr` += `BURST_BEATS*BEAT_BYTES`. When idx = num_bursts−1, it wraps: idx ← 0, `araddr` ← base. `num_bursts`=1 always reissues base.
- Credits: +1 on `wr_burst_done`, −1 on AR handshake; both in the same cycle leaves it unchanged. Saturates at all-ones; an increment at all-ones sets `cred_ovf`.
- Outstanding: +1 on AR handshake, −1 on `rvalid & rready & rlast`; both in the same cycle leaves it unchanged. A decrement at 0 is ignored.
- `underrun`: set when IDLE and `ctrl_rd_en & DDR_rd_en & credits=0`.

## Timing
- Reset values: `arvalid`=0, `araddr`=0, `credits`=0, `outstanding`=0, flags=0, state IDLE.
- Issue condition true in cycle N → `arvalid`=1 in N+1 (registered).
- AR handshake in cycle N → `arvalid`=0 in N+1. First possible next `arvalid` is N+`HOLDOFF`+2.
- Counters update in the cycle after the qualifying edge. The status outputs are registered.
- `rst_n` asserted mid-burst: everything returns to reset values asynchronously. The interconnect must also be reset.

## Structure
- Shared package/header: AXI burst encodings (INCR), state encodings, and the derived `BURST_BYTES` = `BURST_BEATS*BEAT_BYTES`.
- One natural sub-module, `sat_updown_cnt`: saturating up/down counter with an overflow flag. Used for both credits and outstanding.

## Test plan
- Reset, then enable with base 0x1000_0000, num_bursts=3, 5 `wr_burst_done`, `DDR_rd_en` held high, `arready`=1, R returned promptly → expected:
  - `araddr` sequence 0x1000_0000, 0x1000_0200, 0x1000_0400, 0x1000_0000, 0x1000_0200;
  - credits end at 0; then `underrun`=1.
- `arready` held low for 10 cycles, with `ctrl_rd_en` dropped at cycle 3 → expected:
  - `arvalid` and `araddr` stable all 10 cycles;
  - one handshake, then no further AR.
- No R responses, 10 credits, request high → expected:
  - exactly 4 ARs, `outstanding`=4, stall;
  - after one `rlast` handshake, a fifth AR.
- `wr_burst_done` coincident with an AR handshake at credits=1 → expected: credits stays 1.
- Credits at 0xFFFF plus one more `wr_burst_done` → expected: credits=0xFFFF, `cred_ovf`=1.
- Async `rst_n` pulse during ISSUE → expected: `arvalid`=0 immediately, all counters 0.
